// File: rtl/ac_ctrl_seq.sv
// ---------------------------------------------------------------------------
// ac_ctrl_seq -- fetch/decode/execute sequencer for the accumulator datapath.
//
// Runs one instruction at a time from a start pulse until ENDOP (HALT), or
// until a memory access is not acknowledged within TIMEOUT wait cycles
// (ERROR). Both terminal states are left only through rst_i.
//
// Ports
//   clk_i          system clock, rising edge
//   rst_i          asynchronous, active-high reset
//   start_i        one-cycle pulse, begins execution from IDLE
//   opcode_i       current IR contents (latched internally in F3)
//   z_flag_i       ALU zero flag, sampled only in DEC
//   mem_ready_i    memory access complete, sampled in every wait cycle
//   mem_read_o     memory read request
//   mem_write_o    memory write request
//   read_en_o      bus source: 0 none, 1 mem, 2 PC, 3 IR, 4 R, 13 AC
//   ar_load_o      AR loads from bus
//   ir_load_o      IR loads from bus
//   pc_inc_o       PC increments
//   pc_load_o      PC loads from bus
//   r_load_o       R loads from bus
//   ac_write_en_o  AC loads from bus
//   ac_inc_en_o    AC increments
//   ac_clr_en_o    AC clears
//   alu_to_ac_o    AC loads from ALU output
//   alu_op_o       ALU op: 0 pass, 1 add, 2 sub
//   busy_o         high in every state except IDLE, HALT, ERROR
//   done_o         one-cycle pulse on entry to HALT
//   err_o          held high while in ERROR
//
// All outputs come from a register bank loaded with the decode of the next
// state. The three strobes that must coincide with the mem_ready sample
// (ir_load, the LDAC ac_write_en and the jump pc_load) are a registered
// "armed" flag gated with mem_ready_i, so they fire in the very cycle the
// access completes and are forced low by reset together with everything else.
// ---------------------------------------------------------------------------
module ac_ctrl_seq #(
    parameter int OPW     = 8,
    parameter int TIMEOUT = 16
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           start_i,
    input  logic [OPW-1:0] opcode_i,
    input  logic           z_flag_i,
    input  logic           mem_ready_i,
    output logic           mem_read_o,
    output logic           mem_write_o,
    output logic [3:0]     read_en_o,
    output logic           ar_load_o,
    output logic           ir_load_o,
    output logic           pc_inc_o,
    output logic           pc_load_o,
    output logic           r_load_o,
    output logic           ac_write_en_o,
    output logic           ac_inc_en_o,
    output logic           ac_clr_en_o,
    output logic           alu_to_ac_o,
    output logic [1:0]     alu_op_o,
    output logic           busy_o,
    output logic           done_o,
    output logic           err_o
);

    localparam int            CW      = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

    localparam logic [3:0] RE_NONE = 4'd0;
    localparam logic [3:0] RE_MEM  = 4'd1;
    localparam logic [3:0] RE_PC   = 4'd2;
    localparam logic [3:0] RE_R    = 4'd4;
    localparam logic [3:0] RE_AC   = 4'd13;

    localparam logic [OPW-1:0] OP_NOP   = OPW'(8'h00);
    localparam logic [OPW-1:0] OP_LDAC  = OPW'(8'h01);
    localparam logic [OPW-1:0] OP_STAC  = OPW'(8'h02);
    localparam logic [OPW-1:0] OP_CLAC  = OPW'(8'h03);
    localparam logic [OPW-1:0] OP_INAC  = OPW'(8'h04);
    localparam logic [OPW-1:0] OP_ADD   = OPW'(8'h05);
    localparam logic [OPW-1:0] OP_SUB   = OPW'(8'h06);
    localparam logic [OPW-1:0] OP_MVACR = OPW'(8'h07);
    localparam logic [OPW-1:0] OP_MVRAC = OPW'(8'h08);
    localparam logic [OPW-1:0] OP_JUMP  = OPW'(8'h09);
    localparam logic [OPW-1:0] OP_JMPZ  = OPW'(8'h0A);
    localparam logic [OPW-1:0] OP_ENDOP = OPW'(8'hFF);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_F1    = 4'd1,
        S_F2    = 4'd2,
        S_F3    = 4'd3,
        S_DEC   = 4'd4,
        S_X1    = 4'd5,
        S_X2    = 4'd6,
        S_X3    = 4'd7,
        S_HALT  = 4'd8,
        S_ERROR = 4'd9
    } state_t;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic [3:0] read_en;
        logic       ar_load;
        logic       ir_arm;     // ir_load once mem_ready arrives
        logic       pc_inc;
        logic       jp_arm;     // pc_load once mem_ready arrives
        logic       r_load;
        logic       ac_write;
        logic       ld_arm;     // ac_write_en once mem_ready arrives
        logic       ac_inc;
        logic       ac_clr;
        logic       alu_to_ac;
        logic [1:0] alu_op;
        logic       busy;
        logic       done;
        logic       err;
    } ctl_t;

    state_t         state_q, state_d;
    logic [OPW-1:0] op_q, op_d;
    logic [CW-1:0]  cnt_q, cnt_d, cnt_inc_s;
    ctl_t           ctl_q, ctl_d;

    // Saturating increment of the wait counter.
    assign cnt_inc_s = (cnt_q == CNT_MAX) ? cnt_q : (cnt_q + CW'(1));

    // The opcode is captured on the F3 -> DEC edge; the output decode for DEC
    // needs it at that same edge, hence the bypass.
    assign op_d = (state_q == S_F3) ? opcode_i : op_q;

    // Next-state and wait-counter logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_F1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_F1: begin
                state_d = S_F2;
                cnt_d   = {CW{1'b0}};
            end
            S_F2, S_X2: begin
                // Completion wins over a timeout landing in the same cycle.
                if (mem_ready_i) begin
                    state_d = (state_q == S_F2) ? S_F3 : S_F1;
                end else begin
                    cnt_d   = cnt_inc_s;
                    state_d = (cnt_inc_s == CNT_MAX) ? S_ERROR : state_q;
                end
            end
            S_F3: begin
                state_d = S_DEC;
            end
            S_DEC: begin
                case (op_q)
                    OP_LDAC, OP_STAC, OP_JUMP: state_d = S_X1;
                    OP_JMPZ:  state_d = z_flag_i ? S_X1 : S_X3;
                    OP_ENDOP: state_d = S_HALT;
                    default:  state_d = S_F1;
                endcase
            end
            S_X1: begin
                state_d = S_X2;
                cnt_d   = {CW{1'b0}};
            end
            S_X3:    state_d = S_F1;
            S_HALT:  state_d = S_HALT;
            S_ERROR: state_d = S_ERROR;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode of the state being entered, loaded into ctl_q.
    always_comb begin
        ctl_d = '0;
        case (state_d)
            S_F1, S_X1: begin
                ctl_d.read_en = RE_PC;
                ctl_d.ar_load = 1'b1;
            end
            S_F2: begin
                ctl_d.mem_read = 1'b1;
                ctl_d.read_en  = RE_MEM;
                ctl_d.ir_arm   = 1'b1;
            end
            S_F3, S_X3: begin
                ctl_d.pc_inc = 1'b1;
            end
            S_DEC: begin
                case (op_d)
                    OP_CLAC: ctl_d.ac_clr = 1'b1;
                    OP_INAC: ctl_d.ac_inc = 1'b1;
                    OP_ADD: begin
                        ctl_d.alu_op    = 2'd1;
                        ctl_d.alu_to_ac = 1'b1;
                    end
                    OP_SUB: begin
                        ctl_d.alu_op    = 2'd2;
                        ctl_d.alu_to_ac = 1'b1;
                    end
                    OP_MVACR: begin
                        ctl_d.read_en = RE_AC;
                        ctl_d.r_load  = 1'b1;
                    end
                    OP_MVRAC: begin
                        ctl_d.read_en  = RE_R;
                        ctl_d.ac_write = 1'b1;
                    end
                    OP_NOP:  ctl_d.read_en = RE_NONE;
                    default: ctl_d.read_en = RE_NONE;
                endcase
            end
            S_X2: begin
                case (op_d)
                    OP_LDAC: begin
                        ctl_d.mem_read = 1'b1;
                        ctl_d.read_en  = RE_MEM;
                        ctl_d.ld_arm   = 1'b1;
                    end
                    OP_STAC: begin
                        ctl_d.mem_write = 1'b1;
                        ctl_d.read_en   = RE_AC;
                    end
                    OP_JUMP, OP_JMPZ: begin
                        ctl_d.mem_read = 1'b1;
                        ctl_d.read_en  = RE_MEM;
                        ctl_d.jp_arm   = 1'b1;
                    end
                    default: ctl_d.read_en = RE_NONE;
                endcase
            end
            S_HALT:  ctl_d.done = (state_q != S_HALT);
            S_ERROR: ctl_d.err  = 1'b1;
            default: ctl_d.read_en = RE_NONE;
        endcase
        ctl_d.busy = (state_d != S_IDLE) && (state_d != S_HALT) && (state_d != S_ERROR);
    end

    // State, latched opcode, wait counter and output registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            op_q    <= {OPW{1'b0}};
            cnt_q   <= {CW{1'b0}};
            ctl_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            ctl_q   <= ctl_d;
        end
    end

    assign mem_read_o    = ctl_q.mem_read;
    assign mem_write_o   = ctl_q.mem_write;
    assign read_en_o     = ctl_q.read_en;
    assign ar_load_o     = ctl_q.ar_load;
    assign ir_load_o     = ctl_q.ir_arm & mem_ready_i;
    assign pc_inc_o      = ctl_q.pc_inc;
    assign pc_load_o     = ctl_q.jp_arm & mem_ready_i;
    assign r_load_o      = ctl_q.r_load;
    assign ac_write_en_o = ctl_q.ac_write | (ctl_q.ld_arm & mem_ready_i);
    assign ac_inc_en_o   = ctl_q.ac_inc;
    assign ac_clr_en_o   = ctl_q.ac_clr;
    assign alu_to_ac_o   = ctl_q.alu_to_ac;
    assign alu_op_o      = ctl_q.alu_op;
    assign busy_o        = ctl_q.busy;
    assign done_o        = ctl_q.done;
    assign err_o         = ctl_q.err;

endmodule
